// File: rtl/pc_sequencer.sv
// pc_sequencer
//   Fetch-PC sequencer for a 3-stage RV32I pipeline with CSR trap support.
//   Owns the fetch PC and the fetch/decode address tracking. Each cycle it picks
//   the next PC from: sequential, hold, branch, mret or trap vector. It also
//   produces the resume address (epc_o) that the CSR unit writes to mepc. After
//   an mret, trap entry is blocked until one instruction from mepc has issued.
//
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   RUN       | normal fetch; traps are taken as soon as the pipe is unstalled
//   TRAP_WAIT | trap committed while stalled; taken on the first unstalled cycle
//   RET       | mret shadow; traps ignored until the mepc instruction advances
//
// Ports
//   clk          in   clock, rising edge
//   rst          in   synchronous active-low reset
//   stall_i      in   hazard stall (hold PC and fetch/decode register)
//   br_taken_i   in   branch/jump taken in execute
//   br_target_i  in   branch/jump target
//   mret_i       in   mret resolving in execute
//   mepc_i       in   mret return address
//   trap_req_i   in   trap/interrupt request (level)
//   trap_vec_i   in   trap vector
//   pc_o         out  current fetch address (registered)
//   pc_sel_o     out  next-PC source: 0 seq, 1 hold, 2 branch, 3 mret, 4 trap
//   flush_o      out  kill the instruction entering fetch/decode
//   trap_ack_o   out  one-cycle pulse when the trap vector is selected
//   epc_o        out  resume address, valid with trap_ack_o
//   state_o      out  0 RUN, 1 TRAP_WAIT, 2 RET
module pc_sequencer #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall_i,
  input  logic        br_taken_i,
  input  logic [31:0] br_target_i,
  input  logic        mret_i,
  input  logic [31:0] mepc_i,
  input  logic        trap_req_i,
  input  logic [31:0] trap_vec_i,
  output logic [31:0] pc_o,
  output logic [2:0]  pc_sel_o,
  output logic        flush_o,
  output logic        trap_ack_o,
  output logic [31:0] epc_o,
  output logic [1:0]  state_o
);

  typedef enum logic [1:0] {
    ST_RUN       = 2'd0,
    ST_TRAP_WAIT = 2'd1,
    ST_RET       = 2'd2
  } state_e;

  localparam logic [2:0] SEL_SEQ  = 3'd0;
  localparam logic [2:0] SEL_HOLD = 3'd1;
  localparam logic [2:0] SEL_BR   = 3'd2;
  localparam logic [2:0] SEL_MRET = 3'd3;
  localparam logic [2:0] SEL_TRAP = 3'd4;

  state_e      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] fd_pc_q, fd_pc_d;
  logic        fd_valid_q, fd_valid_d;

  logic        redir, s, take, flush;
  logic [2:0]  sel;
  logic [31:0] epc;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_RUN;
      pc_q       <= RESET_PC;
      fd_pc_q    <= RESET_PC;
      fd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_q       <= pc_d;
      fd_pc_q    <= fd_pc_d;
      fd_valid_q <= fd_valid_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    take       = 1'b0;
    pc_d       = pc_q + 32'd4;
    sel        = SEL_SEQ;
    epc        = 32'h0;
    fd_pc_d    = fd_pc_q;
    fd_valid_d = fd_valid_q;

    // A redirect overrides a stall, so a redirect never holds the pipe.
    redir = br_taken_i | mret_i;
    s     = stall_i & ~redir;

    unique case (state_q)
      ST_RUN: begin
        if (trap_req_i && !s)      take    = 1'b1;
        else if (trap_req_i && s)  state_d = ST_TRAP_WAIT;
        else if (mret_i)           state_d = ST_RET;
      end
      ST_TRAP_WAIT: begin
        // Request is committed; it is not re-sampled here.
        if (!s) begin
          take    = 1'b1;
          state_d = ST_RUN;
        end
      end
      ST_RET: begin
        // Exit once the mepc instruction moves from fetch/decode to execute.
        if (mret_i)                  state_d = ST_RET;
        else if (fd_valid_q && !s)   state_d = ST_RUN;
      end
      default: state_d = ST_RUN;
    endcase

    if (take) begin
      pc_d = trap_vec_i;
      sel  = SEL_TRAP;
      if (mret_i)           epc = mepc_i;
      else if (br_taken_i)  epc = br_target_i;
      else if (fd_valid_q)  epc = fd_pc_q;
      else                  epc = pc_q;
    end else if (mret_i) begin
      pc_d = mepc_i;
      sel  = SEL_MRET;
    end else if (br_taken_i) begin
      pc_d = br_target_i;
      sel  = SEL_BR;
    end else if (s) begin
      pc_d = pc_q;
      sel  = SEL_HOLD;
    end

    flush = take | redir;

    if (!s) begin
      fd_pc_d    = pc_q;
      fd_valid_d = ~flush;
    end
  end

  always_comb begin
    if (!rst) begin
      pc_sel_o   = SEL_HOLD;
      flush_o    = 1'b1;
      trap_ack_o = 1'b0;
      epc_o      = 32'h0;
    end else begin
      pc_sel_o   = sel;
      flush_o    = flush;
      trap_ack_o = take;
      epc_o      = epc;
    end
  end

  assign pc_o    = pc_q;
  assign state_o = state_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed-vector bench for pc_sequencer. Inputs change 1 time unit after the
// rising edge; combinational outputs are sampled a little later in the cycle.
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall_i, br_taken_i, mret_i, trap_req_i;
  logic [31:0] br_target_i, mepc_i, trap_vec_i;
  logic [31:0] pc_o, epc_o;
  logic [2:0]  pc_sel_o;
  logic        flush_o, trap_ack_o;
  logic [1:0]  state_o;

  int n_vec = 0;
  int n_bad = 0;

  pc_sequencer #(.RESET_PC(32'h0000_0000)) dut (
    .clk        (clk),
    .rst        (rst),
    .stall_i    (stall_i),
    .br_taken_i (br_taken_i),
    .br_target_i(br_target_i),
    .mret_i     (mret_i),
    .mepc_i     (mepc_i),
    .trap_req_i (trap_req_i),
    .trap_vec_i (trap_vec_i),
    .pc_o       (pc_o),
    .pc_sel_o   (pc_sel_o),
    .flush_o    (flush_o),
    .trap_ack_o (trap_ack_o),
    .epc_o      (epc_o),
    .state_o    (state_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    n_vec++;
    if (obs !== exp_v) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic idle_inputs();
    stall_i = 0; br_taken_i = 0; mret_i = 0; trap_req_i = 0;
    br_target_i = 0; mepc_i = 0; trap_vec_i = 0;
  endtask

  initial begin
    rst = 0;
    idle_inputs();

    // Reset held for two edges
    tick(); tick(); settle();
    chk("rst_pc",    pc_o, 32'h0);
    chk("rst_flush", {31'b0, flush_o}, 32'd1);
    chk("rst_sel",   {29'b0, pc_sel_o}, 32'd1);
    chk("rst_ack",   {31'b0, trap_ack_o}, 32'd0);
    chk("rst_epc",   epc_o, 32'h0);
    chk("rst_state", {30'b0, state_o}, 32'd0);

    rst = 1; settle();
    chk("seq0_pc",  pc_o, 32'h0);
    chk("seq0_sel", {29'b0, pc_sel_o}, 32'd0);
    chk("seq0_flush", {31'b0, flush_o}, 32'd0);
    tick(); settle(); chk("seq1_pc", pc_o, 32'h4);
    tick(); settle(); chk("seq2_pc", pc_o, 32'h8);
    tick(); tick(); settle(); chk("seq4_pc", pc_o, 32'h10);

    // Branch overriding a stall
    br_taken_i = 1; br_target_i = 32'h40; stall_i = 1; settle();
    chk("br_flush", {31'b0, flush_o}, 32'd1);
    chk("br_sel",   {29'b0, pc_sel_o}, 32'd2);
    tick(); idle_inputs(); settle();
    chk("br_pc", pc_o, 32'h40);
    // fd register is invalid after the flush, so epc falls back to pc
    trap_req_i = 1; trap_vec_i = 32'h200; settle();
    chk("brtrap_ack", {31'b0, trap_ack_o}, 32'd1);
    chk("brtrap_epc", epc_o, 32'h40);
    chk("brtrap_sel", {29'b0, pc_sel_o}, 32'd4);
    tick(); idle_inputs(); settle();
    chk("brtrap_pc", pc_o, 32'h200);

    // Unstalled trap with valid fd register
    br_taken_i = 1; br_target_i = 32'h18;
    tick(); idle_inputs(); tick(); tick(); settle();
    chk("t1_pc", pc_o, 32'h20);
    trap_req_i = 1; trap_vec_i = 32'h100; settle();
    chk("t1_ack",   {31'b0, trap_ack_o}, 32'd1);
    chk("t1_epc",   epc_o, 32'h1C);
    chk("t1_flush", {31'b0, flush_o}, 32'd1);
    chk("t1_sel",   {29'b0, pc_sel_o}, 32'd4);
    tick(); idle_inputs(); settle();
    chk("t1_vec",  pc_o, 32'h100);
    chk("t1_ack0", {31'b0, trap_ack_o}, 32'd0);

    // Trap under a 3-cycle stall, request dropped after the first cycle
    tick(); tick(); settle();
    chk("t2_pc0", pc_o, 32'h108);
    stall_i = 1; trap_req_i = 1; trap_vec_i = 32'h300; settle();
    chk("t2_a_ack", {31'b0, trap_ack_o}, 32'd0);
    chk("t2_a_sel", {29'b0, pc_sel_o}, 32'd1);
    tick(); trap_req_i = 0; settle();
    chk("t2_b_state", {30'b0, state_o}, 32'd1);
    chk("t2_b_pc",    pc_o, 32'h108);
    chk("t2_b_ack",   {31'b0, trap_ack_o}, 32'd0);
    tick(); settle();
    chk("t2_c_state", {30'b0, state_o}, 32'd1);
    chk("t2_c_pc",    pc_o, 32'h108);
    chk("t2_c_ack",   {31'b0, trap_ack_o}, 32'd0);
    tick(); stall_i = 0; settle();
    chk("t2_d_state", {30'b0, state_o}, 32'd1);
    chk("t2_d_ack",   {31'b0, trap_ack_o}, 32'd1);
    chk("t2_d_epc",   epc_o, 32'h104);
    tick(); idle_inputs(); settle();
    chk("t2_vec",   pc_o, 32'h300);
    chk("t2_state", {30'b0, state_o}, 32'd0);

    // Trap together with branch
    br_taken_i = 1; br_target_i = 32'h80; trap_req_i = 1; trap_vec_i = 32'h100; settle();
    chk("t3_sel", {29'b0, pc_sel_o}, 32'd4);
    chk("t3_epc", epc_o, 32'h80);
    chk("t3_ack", {31'b0, trap_ack_o}, 32'd1);
    tick(); idle_inputs(); settle();
    chk("t3_pc", pc_o, 32'h100);

    // mret shadow
    mret_i = 1; mepc_i = 32'h24; settle();
    chk("m_sel",   {29'b0, pc_sel_o}, 32'd3);
    chk("m_flush", {31'b0, flush_o}, 32'd1);
    tick(); idle_inputs(); trap_req_i = 1; trap_vec_i = 32'h400; settle();
    chk("m0_pc",    pc_o, 32'h24);
    chk("m0_state", {30'b0, state_o}, 32'd2);
    chk("m0_ack",   {31'b0, trap_ack_o}, 32'd0);
    tick(); settle();
    chk("m1_pc",    pc_o, 32'h28);
    chk("m1_state", {30'b0, state_o}, 32'd2);
    chk("m1_ack",   {31'b0, trap_ack_o}, 32'd0);
    tick(); settle();
    chk("m2_state", {30'b0, state_o}, 32'd0);
    chk("m2_ack",   {31'b0, trap_ack_o}, 32'd1);
    chk("m2_epc",   epc_o, 32'h28);
    chk("m2_sel",   {29'b0, pc_sel_o}, 32'd4);
    tick(); idle_inputs(); settle();
    chk("m_vec", pc_o, 32'h400);

    // PC wrap at 2^32
    br_taken_i = 1; br_target_i = 32'hFFFF_FFFC;
    tick(); idle_inputs(); settle();
    chk("wrap0", pc_o, 32'hFFFF_FFFC);
    tick(); settle();
    chk("wrap1", pc_o, 32'h0);

    // mret beats branch
    mret_i = 1; mepc_i = 32'h50; br_taken_i = 1; br_target_i = 32'h60; settle();
    chk("mb_sel", {29'b0, pc_sel_o}, 32'd3);
    tick(); idle_inputs(); settle();
    chk("mb_pc",    pc_o, 32'h50);
    chk("mb_state", {30'b0, state_o}, 32'd2);
    tick(); tick(); settle();
    chk("mb_exit", {30'b0, state_o}, 32'd0);

    // Reset in the middle of a committed trap
    stall_i = 1; trap_req_i = 1; trap_vec_i = 32'h500;
    tick(); settle();
    chk("mr_state", {30'b0, state_o}, 32'd1);
    rst = 0; stall_i = 0; settle();
    chk("mr_ack",   {31'b0, trap_ack_o}, 32'd0);
    chk("mr_flush", {31'b0, flush_o}, 32'd1);
    chk("mr_sel",   {29'b0, pc_sel_o}, 32'd1);
    tick(); rst = 1; idle_inputs(); settle();
    chk("mr_pc",     pc_o, 32'h0);
    chk("mr_state1", {30'b0, state_o}, 32'd0);
    chk("mr_ack1",   {31'b0, trap_ack_o}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
# pc_sequencer

Fetch-PC sequencer for the 3-stage RV32I pipeline with CSR trap support. It owns the fetch PC register and the fetch/decode-address tracking. Each cycle it chooses among sequential, hold, branch, mret and trap-vector targets, and computes the resume address (`epc_o`) that the CSR unit writes to mepc. It also guarantees forward progress after `mret` by blocking trap entry until one instruction from mepc has issued.

## Interface
- `RESET_PC`, default 32'h0000_0000: fetch address loaded at reset.
- `clk`  in  1: single clock; all state updates on the rising edge.
- `rst`  in  1: synchronous, active-low reset.
- `stall_i`  in  1: hazard stall; hold PC and the fetch/decode register.
- `br_taken_i`  in  1: branch/jump resolved taken in execute.
- `br_target_i`  in  32: branch/jump target (ALU result).
- `mret_i`  in  1: mret resolving in execute.
- `mepc_i`  in  32: mret return address from CSR file.
- `trap_req_i`  in  1: CSR trap/interrupt request, level.
- `trap_vec_i`  in  32: trap vector from CSR file.
- `pc_o`  out  32: current fetch address, registered.
- `pc_sel_o`  out  3: next-PC source: 0 seq, 1 hold, 2 branch, 3 mret, 4 trap.
- `flush_o`  out  1: kill the instruction entering the fetch/decode register.
- `trap_ack_o`  out  1: one-cycle pulse in the cycle the trap vector is selected.
- `epc_o`  out  32: resume address; valid only when `trap_ack_o`=1.
- `state_o`  out  2: FSM state: 0 RUN, 1 TRAP_WAIT, 2 RET.

## Operation
**Internal registers**
- `pc_q` drives `pc_o`.
- `fd_pc_q` holds the address of the instruction in the fetch/decode register.
- `fd_valid_q` marks that register as valid.

**Redirect and stall rules**
- Redirect: `redir` = `br_taken_i` | `mret_i`.
- Effective stall: `s` = `stall_i` & !`redir`. A redirect overrides a stall.
- `mret_i` and `br_taken_i` together: mret wins.

**Trap take (`take`)** loads `pc_q`<=`trap_vec_i` and asserts `flush_o`=1 and `trap_ack_o`=1. `epc_o` is selected in priority order:
- `mepc_i` if `mret_i`;
- else `br_target_i` if `br_taken_i`;
- else `fd_pc_q` if `fd_valid_q`;
- else `pc_q`.

**Next PC when not taking a trap**
- `mret_i`: `pc_q`<=`mepc_i`.
- else `br_taken_i`: `pc_q`<=`br_target_i`.
- else `s`: hold `pc_q`.
- else: `pc_q`<=`pc_q`+4, mod 2^32 (0xFFFF_FFFC wraps to 0).

**`flush_o`** = `take` | `redir`.

**Fetch/decode tracking**
- If !`s`: `fd_pc_q`<=`pc_q` and `fd_valid_q`<=!`flush_o`.
- If `s`: both hold.

**FSM**
- RUN:
  - `trap_req_i` & !`s`: `take`, stay in RUN.
  - `trap_req_i` & `s`: go to TRAP_WAIT.
  - `mret_i` (no trap): go to RET.
- TRAP_WAIT:
  - The trap is committed: `trap_req_i` is not re-sampled and its deassertion does not cancel the trap.
  - PC holds while `s`=1.
  - On the first cycle with `s`=0: `take`, go to RUN.
  - A redirect in this state makes `s`=0, so `take` happens in that cycle with epc = redirect target.
- RET:
  - `trap_req_i` is ignored.
  - Exit to RUN in the cycle where `fd_valid_q`=1 and `s`=0; the instruction from mepc advances to execute.
  - `trap_req_i` is still ignored in that exit cycle.
  - A further `mret_i` in RET stays in RET.

**Reset**
- While `rst`=0, at each edge: `pc_q`=`RESET_PC`, `fd_pc_q`=`RESET_PC`, `fd_valid_q`=0, state=RUN.
- Combinational outputs are forced while `rst`=0: `flush_o`=1, `trap_ack_o`=0, `pc_sel_o`=1, `epc_o`=0.
- Reset mid-trap (TRAP_WAIT or RET) abandons the sequence; no ack is issued.

## Timing
- `pc_o` is registered. A new target is visible the cycle after selection.
- `pc_sel_o`, `flush_o`, `trap_ack_o` and `epc_o` are combinational from state and inputs in the same cycle.
- Trap latency from `trap_req_i` to vector on `pc_o`:
  - RUN, unstalled: 1 cycle.
  - Stalled: 1 cycle plus the number of stalled cycles.
  - RET: deferred until exit plus 1 cycle.
- `trap_ack_o` is exactly one cycle per trap. The CSR unit samples `epc_o` and `trap_vec_i` in that cycle.
- Back-to-back traps: if `trap_req_i` is still high in the cycle after ack, a second trap is taken. The CSR unit must drop the request on ack.

## Test plan
- Reset: hold `rst`=0 for 2 cycles, `RESET_PC`=0 → `pc_o`=0, `flush_o`=1, `pc_sel_o`=1. After release, `pc_o` sequence is 0, 4, 8, `pc_sel_o`=0.
- Branch: at `pc_o`=0x10, `br_taken_i`=1, target 0x40, `stall_i`=1 → `flush_o`=1, `pc_sel_o`=2, next `pc_o`=0x40. The following cycle `fd_valid_q`=0.
- Trap, unstalled: `pc_o`=0x20, fd holds 0x1C (valid), `trap_req_i`=1, vec 0x100 → `trap_ack_o`=1, `epc_o`=0x1C, `flush_o`=1, next `pc_o`=0x100.
- Trap under 3-cycle stall: `state_o`=1 for 3 cycles, `pc_o` held, no ack. `trap_req_i` dropped after cycle 1 → ack still occurs on the 4th cycle with `epc_o`=`fd_pc_q`.
- Trap and branch together: target 0x80, vec 0x100 → `pc_o`=0x100, `epc_o`=0x80, `pc_sel_o`=4.
- mret shadow: `mret_i` with mepc 0x24 while `trap_req_i` is held high.
  - Cycle 0: `pc_o` becomes 0x24, `state_o`=2.
  - Cycles 1–2: no ack.
  - Cycle 3: ack with `epc_o`=0x28 and `pc_o` becomes the vector.
